// File: rtl/led_uart_reporter_if.sv
// rtl/led_uart_reporter_if.sv - LED capture input and serial/status outputs of the reporter
interface led_uart_reporter_if #(
    parameter int LVL_W          = 3,
    parameter int DROP_CNT_WIDTH = 8
);
    logic [7:0]                LED_IN;
    logic                      TXD;
    logic                      BUSY;
    logic [LVL_W-1:0]          FIFO_LEVEL;
    logic [DROP_CNT_WIDTH-1:0] DROP_CNT;

    modport master (
        output LED_IN,
        input  TXD,
        input  BUSY,
        input  FIFO_LEVEL,
        input  DROP_CNT
    );

    modport slave (
        input  LED_IN,
        output TXD,
        output BUSY,
        output FIFO_LEVEL,
        output DROP_CNT
    );
endinterface

// File: rtl/led_uart_reporter.sv
// rtl/led_uart_reporter.sv - captures LED value changes into a FIFO and sends them 8N1 on TXD
module led_uart_reporter #(
    parameter int CLKS_PER_BIT   = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic              CLK,
    input  logic              RST,
    led_uart_reporter_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // change detector
    logic [7:0] prev_q;
    logic       prev_valid_q;
    logic       push_req;

    // capture FIFO
    logic [7:0]                mem_q [FIFO_DEPTH];
    logic [AW-1:0]             wr_q;
    logic [AW-1:0]             rd_q;
    logic [LW-1:0]             level_q;
    logic [DROP_CNT_WIDTH-1:0] drop_q;
    logic                      full;
    logic                      empty;
    logic                      push;
    logic                      drop;
    logic [7:0]                head;

    // transmitter
    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          pop;
    logic          timer_done;

    assign push_req   = !prev_valid_q || (bus.LED_IN != prev_q);
    assign full       = (level_q == LW'(FIFO_DEPTH));
    assign empty      = (level_q == '0);
    // A full FIFO still accepts a value on an edge where the transmitter frees a slot.
    assign push       = push_req && (!full || pop);
    assign drop       = push_req && full && !pop;
    assign head       = mem_q[rd_q];
    assign timer_done = (timer_q == TW'(CLKS_PER_BIT - 1));

    assign bus.TXD        = txd_q;
    assign bus.BUSY       = (state_q != S_IDLE);
    assign bus.FIFO_LEVEL = level_q;
    assign bus.DROP_CNT   = drop_q;

    // Remember the last sampled LED value so only changes are queued.
    always_ff @(posedge CLK) begin
        if (RST) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            prev_q       <= bus.LED_IN;
            prev_valid_q <= 1'b1;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge CLK) begin
        if (!RST && push) begin
            mem_q[wr_q] <= bus.LED_IN;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_q <= wr_q + AW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Saturating count of values lost to a full FIFO.
    always_ff @(posedge CLK) begin
        if (RST) begin
            drop_q <= '0;
        end else if (drop && (drop_q != '1)) begin
            drop_q <= drop_q + DROP_CNT_WIDTH'(1);
        end
    end

    // Transmitter state register; TXD is registered so it idles high out of reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    // Transmitter next state: txd_d is the line level for the state being entered.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q + TW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                txd_d   = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    state_d = S_START;
                    txd_d   = 1'b0;
                end
            end
            S_START: begin
                if (timer_done) begin
                    state_d = S_DATA;
                    timer_d = '0;
                    bit_d   = '0;
                    txd_d   = shift_q[0];
                end
            end
            S_DATA: begin
                if (timer_done) begin
                    timer_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        txd_d   = shift_q[1];
                    end
                end
            end
            S_STOP: begin
                if (timer_done) begin
                    timer_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        state_d = S_START;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        txd_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
                txd_d   = 1'b1;
            end
        endcase
    end
endmodule

// File: doc/led_uart_reporter.md
# led_uart_reporter

Downstream consumer of the free-running counter stage's 8-bit LED output. Each new value on LED_IN is captured into a small FIFO and serialized on a single UART-style line (8N1, LSB first) for board-level observation. Values that arrive faster than the line can send them are dropped and counted.

## Interface
- CLKS_PER_BIT, default 4: clock cycles per serial bit; must be ≥ 2.
- FIFO_DEPTH, default 4: capture FIFO entries; must be a power of 2 and ≥ 2.
- DROP_CNT_WIDTH, default 8: width of the drop counter.
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- LED_IN  in  8  value from the upstream counter stage; sampled every edge.
- TXD  out  1  serial output, registered; idles high.
- BUSY  out  1  high whenever the transmit FSM is not in IDLE.
- FIFO_LEVEL  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- DROP_CNT  out  DROP_CNT_WIDTH  number of values dropped; saturates at the all-ones value.

## Operation
- Change detector:
  - Registers prev (8 bits) and prev_valid.
  - Push request on an edge when !prev_valid, or when LED_IN != prev.
  - On every non-reset edge: prev <= LED_IN and prev_valid <= 1.
  - The first sampled value after reset is therefore always pushed.
- FIFO:
  - Push when a request arrives and the FIFO is not full.
  - Request while full and no pop on the same edge: the value is discarded and DROP_CNT increments, saturating.
  - Push and pop on the same edge, including when full: both happen and occupancy is unchanged.
- Transmit FSM states:
  - IDLE: if FIFO_LEVEL != 0, pop the head into the shift register and go to START.
  - START: TXD=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each, then STOP.
  - STOP: TXD=1 for CLKS_PER_BIT cycles, then go to START (popping in the same edge) if the FIFO is non-empty, else IDLE.
- Bit timer counts 0..CLKS_PER_BIT-1 and is cleared on every state or bit transition.
- Reset values:
  - Outputs: TXD=1, BUSY=0, FIFO_LEVEL=0, DROP_CNT=0.
  - Internal: FSM=IDLE, prev_valid=0, FIFO pointers=0.
- Reset mid-frame: the frame is abandoned, TXD is 1 after the reset edge, and FIFO contents are flushed.

## Timing
- LED_IN differs from prev before edge k: the entry is written at edge k and FIFO_LEVEL increments after k.
- If the FSM is IDLE at edge k+1: pop at k+1, TXD low and BUSY high after k+1.
- Frame length is 10*CLKS_PER_BIT cycles (40 at default).
- Back-to-back frames: the next start bit begins on the edge immediately after the last stop-bit cycle, with no idle gap.
- BUSY falls on the edge ending STOP only when the FIFO is empty.
- A value held constant for any number of cycles produces exactly one frame.

## Test plan
- **Reset, then hold LED_IN=0x00.**
  - Exactly one frame: TXD low for 36 cycles (start plus 8 zero bits), then high for 4 stop cycles.
  - BUSY high for 40 cycles, then 0.
  - DROP_CNT=0, and no further frames.
- **After idle, step LED_IN 0x00→0xA5 and hold.**
  - Data bits on TXD, in order: 1,0,1,0,0,1,0,1.
  - Start bit begins after the edge following the capture edge.
- **Burst, FSM idle: LED_IN takes 0x01..0x0A on 10 consecutive edges.**
  - First edge pushes; second edge pops 0x01 and pushes 0x02.
  - FIFO reaches 4 by the 5th edge; the 5 later values are dropped and DROP_CNT=5.
  - Frames 0x01,0x02,0x03,0x04,0x05 are sent back-to-back: 200 cycles of BUSY with no idle gap.
- **Saturation: 300 overflow drops.**
  - DROP_CNT stops at 0xFF.
  - TXD frames of the accepted values are unaffected.
- **Reset mid-frame: assert RST for 1 cycle during DATA bit 3 with 2 entries queued.**
  - TXD=1, BUSY=0, FIFO_LEVEL=0 after the reset edge.
  - The next edge pushes the current LED_IN, and a new frame starts one edge later.
- **Revisit: LED_IN 0x11→0x22→0x11, each held 100 cycles.**
  - Exactly three frames: 0x11, 0x22, 0x11.
  - DROP_CNT=0.
